// File: rtl/iir_ff_mac.sv
// Serial feed-forward MAC stage: one multiplier sums N taps per sample.
// Define IIR_FF_MAC_SATURATE_EN to clamp y instead of wrapping it.
module iir_ff_mac #(
    parameter int PRECISION   = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int N           = 4,
    parameter int FRAC_BITS   = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PRECISION-1:0]     x,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [COEFF_WIDTH*N-1:0] packed_b_coeffs,
    output logic [PRECISION-1:0]     y,
    output logic                     y_valid
);

    localparam int ACC_W = PRECISION + COEFF_WIDTH + $clog2(N);
    localparam int PW    = PRECISION + COEFF_WIDTH;
    localparam int K_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [ACC_W-1:0] HALF =
        {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   last;

    logic signed [PRECISION-1:0]   tap  [N];
    logic signed [COEFF_WIDTH-1:0] b_sh [N];
    logic signed [ACC_W-1:0]       acc;
    logic        [K_W-1:0]         k;

    logic signed [PW-1:0]          prod;
    logic signed [ACC_W-1:0]       rnd;
    logic signed [ACC_W-1:0]       r;
    logic        [PRECISION-1:0]   y_nxt;

    assign last = (k == K_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (x_valid) state_nxt = MAC;
            MAC:     if (last)    state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        x_ready = (state == IDLE) && !rst;
        accept  = x_ready && x_valid;
    end

    assign prod = tap[k] * b_sh[k];
    assign rnd  = acc + HALF;
    assign r    = rnd >>> FRAC_BITS;

`ifdef IIR_FF_MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-PRECISION+1){1'b0}}, {(PRECISION-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        if (r > SAT_MAX)      y_nxt = {1'b0, {(PRECISION-1){1'b1}}};
        else if (r < SAT_MIN) y_nxt = {1'b1, {(PRECISION-1){1'b0}}};
        else                  y_nxt = r[PRECISION-1:0];
    end
`else
    logic unused_hi;
    assign unused_hi = ^r[ACC_W-1:PRECISION];
    assign y_nxt     = r[PRECISION-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < N; t++) begin
                tap[t]  <= '0;
                b_sh[t] <= '0;
            end
            acc     <= '0;
            k       <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            if (accept) begin
                for (int t = N - 1; t > 0; t--) tap[t] <= tap[t-1];
                tap[0] <= x;
                for (int t = 0; t < N; t++)
                    b_sh[t] <= packed_b_coeffs[COEFF_WIDTH*t +: COEFF_WIDTH];
                acc <= '0;
                k   <= '0;
            end else if (state == MAC) begin
                acc <= acc + ACC_W'(prod);
                if (!last) k <= k + K_W'(1);
            end else if (state == OUT) begin
                y       <= y_nxt;
                y_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iir_ff_mac.sv
// Scoreboard bench for iir_ff_mac: directed vectors, queued expectations.
// Monitor pops one expectation per y_valid pulse and checks value and latency.
module tb_iir_ff_mac;

    localparam int P  = 16;
    localparam int CW = 16;
    localparam int N  = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic signed [P-1:0]   x = '0;
    logic                  x_valid = 1'b0;
    logic                  x_ready;
    logic [CW*N-1:0]       packed_b = '0;
    logic signed [P-1:0]   y;
    logic                  y_valid;

    always #5 clk = ~clk;

    iir_ff_mac #(
        .PRECISION(P), .COEFF_WIDTH(CW), .N(N), .FRAC_BITS(14)
    ) dut (
        .clk(clk),
        .rst(rst),
        .x(x),
        .x_valid(x_valid),
        .x_ready(x_ready),
        .packed_b_coeffs(packed_b),
        .y(y),
        .y_valid(y_valid)
    );

    typedef struct {
        int ey;
        int edge_n;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   pass_cnt = 0;
    int   tot_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        tot_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: samples just after each rising edge.
    logic prev_yv = 1'b0;
    int   lowrun = 0;
    bit   skip = 1'b1;
    exp_t e;
    always begin
        @(posedge clk);
        #1;
        if (y_valid) begin
            chk("y_valid_single_pulse", int'(prev_yv), 0);
            chk("x_ready_with_y_valid", int'(x_ready), 1);
            chk("y_valid_expected", exp_q.size() > 0 ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("y_value", int'(y), e.ey);
                chk("latency_edges", cyc - e.edge_n, 5);
            end
        end
        prev_yv = y_valid;
        if (rst) begin
            lowrun = 0;
            skip   = 1'b1;
        end else if (!x_ready) begin
            lowrun++;
        end else begin
            if (lowrun > 0 && !skip) chk("x_ready_low_cycles", lowrun, 5);
            lowrun = 0;
            skip   = 1'b0;
        end
    end

    task automatic set_b(input int b0, input int b1, input int b2, input int b3);
        packed_b = {CW'(b3), CW'(b2), CW'(b1), CW'(b0)};
    endtask

    task automatic send(input int v, input int ey, input bit push, output int ae);
        int n;
        @(negedge clk);
        x       = P'(v);
        x_valid = 1'b1;
        n       = 0;
        while (!x_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!x_ready) begin
            tot_cnt++;
            $display("FAIL accept_timeout: x_ready stayed %0d, required 1", x_ready);
            x_valid = 1'b0;
            ae      = -1;
        end else begin
            ae = cyc + 1;
            if (push) exp_q.push_back('{ey: ey, edge_n: ae});
            @(posedge clk);
        end
    endtask

    task automatic stream(input int xs[5], input int es[5], input int n);
        int ae;
        int prev_ae;
        prev_ae = -1;
        for (int i = 0; i < n; i++) begin
            send(xs[i], es[i], 1'b1, ae);
            if (i > 0 && ae >= 0 && prev_ae >= 0)
                chk("accept_spacing", ae - prev_ae, 6);
            prev_ae = ae;
        end
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        x_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_y", int'(y), 0);
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_x_ready", int'(x_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("x_ready_after_rst", int'(x_ready), 1);
    endtask

    int ae;

    initial begin
        do_reset();

        set_b(16384, 8192, 4096, -16384);
        stream('{1000, 0, 0, 0, 0}, '{1000, 500, 250, -1000, 0}, 5);
        drain();

        do_reset();
        set_b(16384, 16384, 16384, 16384);
`ifdef IIR_FF_MAC_SATURATE_EN
        stream('{30000, 30000, 30000, 30000, 0},
               '{30000, 32767, 32767, 32767, 0}, 4);
`else
        stream('{30000, 30000, 30000, 30000, 0},
               '{30000, -5536, 24464, -11072, 0}, 4);
`endif
        drain();

        do_reset();
        set_b(8192, 0, 0, 0);
        stream('{3, 0, 0, 0, 0}, '{2, 0, 0, 0, 0}, 1);
        drain();
        do_reset();
        stream('{-3, 0, 0, 0, 0}, '{-1, 0, 0, 0, 0}, 1);
        drain();

        // Abort a computation with a one-cycle reset sampled at E2.
        do_reset();
        set_b(16384, 8192, 4096, -16384);
        send(1000, 0, 1'b0, ae);
        @(negedge clk);
        x_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("x_ready_after_abort", int'(x_ready), 1);
        repeat (10) @(negedge clk);
        stream('{1000, 0, 0, 0, 0}, '{1000, 500, 250, -1000, 0}, 5);
        drain();

        // Coefficients change at E1; that output keeps the latched set.
        do_reset();
        set_b(16384, 8192, 4096, -16384);
        send(1000, 1000, 1'b1, ae);
        @(negedge clk);
        set_b(0, 0, 0, 0);
        x_valid = 1'b0;
        send(500, 0, 1'b1, ae);
        @(negedge clk);
        x_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/iir_ff_mac.md
# iir_ff_mac

Parametrised, resource-shared feed-forward (FIR/zero) stage for the configurable IIR filter chain. A single multiplier accumulates the N-tap sum serially, using a valid/ready input handshake and a valid-pulse output. Coefficients are in Q-format fixed point, the result is rounded, and overflow saturation can be configured. The block sits between the ADC sample conditioning and the IIR feedback stage in the analogue front-end path.

## Interface
- PRECISION, 16: sample width for x and y (signed, two's complement).
- COEFF_WIDTH, 16: width of each b coefficient (signed).
- N, 4: number of taps, b[0]..b[N-1]; N ≥ 1.
- FRAC_BITS, 14: fractional bits of the coefficients; 1 ≤ FRAC_BITS < COEFF_WIDTH (16384 = 1.0 at defaults).

- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- x  input  PRECISION  signed input sample.
- x_valid  input  1  x is presented.
- x_ready  output  1  block can accept a sample; equals (state==IDLE) && !rst.
- packed_b_coeffs  input  COEFF_WIDTH*N  b[t] = bits [COEFF_WIDTH*t +: COEFF_WIDTH].
- y  output  PRECISION  signed filtered output, registered.
- y_valid  output  1  one-cycle pulse; y is new.

## Operation
- Delay line tap[0..N-1], PRECISION bits each. tap[0] is the newest sample.
- Accumulator width is ACC_W = PRECISION + COEFF_WIDTH + clog2(N). Products are sign-extended to ACC_W, and the sum cannot overflow.
- States:
  - IDLE: x_ready=1. When x_valid && x_ready: shift in x (tap[0]<=x, tap[k]<=tap[k-1]), latch all coefficients into a shadow register, clear acc, set k=0, and go to MAC.
  - MAC: acc += tap[k]*b_shadow[k] for one tap per cycle. When k==N-1, go to OUT; otherwise k++.
  - OUT: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, which rounds half toward +∞. Apply saturation or wrap to r (see Configuration), register y, pulse y_valid, and go to IDLE.
- Changes to packed_b_coeffs during MAC/OUT have no effect until the next accept.
- x_valid is ignored outside IDLE. The upstream source must hold x until it is accepted.
- rst: clears all taps, acc, k, y, and the shadow coefficients to 0, sets y_valid=0 and state=IDLE. Reset during MAC/OUT aborts the computation, and no y_valid is produced for the aborted sample.
- Reset values: y=0, y_valid=0, x_ready=0 while rst=1, and x_ready=1 on the first cycle after rst falls.

## Timing
- The accept edge is E0. MAC runs on edges E1..EN. y and y_valid are registered at E(N+1), so latency is N+1 edges.
- x_ready falls after E0 and returns high after E(N+1), in the same cycle that y_valid is high.
- The earliest next accept is E(N+2). Sustained throughput is one sample per N+2 cycles (6 at N=4).
- y holds its value between pulses. y_valid is never high for two consecutive cycles.

## Configuration
- Macro IIR_FF_MAC_SATURATE_EN.
  - Defined: r is clamped to [−2^(PRECISION−1), 2^(PRECISION−1)−1].
  - Undefined: y is the low PRECISION bits of r (two's-complement wrap), with no clamp logic.

## Test plan
Defaults throughout (N=4, PRECISION=16, COEFF_WIDTH=16, FRAC_BITS=14), with x_valid held continuously high unless stated.
- Impulse: b=[16384, 8192, 4096, −16384], x=1000,0,0,0,0 → y=1000, 500, 250, −1000, 0. Each y_valid fires exactly 5 edges after its accept edge.
- Overflow: b all 16384, x=30000 ×4.
  - With the macro defined: y=30000, 32767, 32767, 32767.
  - Without the macro: y=30000, −5536, 24464, −11072.
- Rounding: b=[8192,0,0,0], x=3 → y=2; then x=−3 after reset → y=−1.
- Throughput/backpressure: x_ready is low for 5 cycles after each accept, accepts occur every 6 cycles, and exactly one y_valid pulse occurs per accept.
- Reset mid-MAC: assert rst for 1 cycle at E2 after an accept.
  - Required: no y_valid, and x_ready=1 the cycle after rst falls.
  - Required: a subsequent impulse of 1000 yields the clean impulse response from the first scenario.
- Coefficient hold: change b to all 0 at E1 of a computation → that output uses the old b. The next sample's output uses zeros (y=0).
